// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Breakout game-flow controller. It sequences serve, play and
//               loss, generates the ball and brick strobes, and keeps lives,
//               score and the remaining-brick count.
//               The optional feature is GAME_SEQUENCER_AUTO_SERVE_EN, which
//               launches the ball automatically once the serve hold expires.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int LIVES_INIT       = 3,
    parameter int BRICK_COUNT      = 28,
    parameter int POINTS_PER_BRICK = 1,
    parameter int SCORE_W          = 10,
    parameter int SERVE_DELAY      = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               refresh_tick,
    input  logic               start_press,
    input  logic               ball_died,
    input  logic               brick_destroyed,
    output logic               ball_reset,
    output logic               launch,
    output logic               bricks_reset,
    output logic [2:0]         game_state,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               paddle_enable
);

    localparam int BRICK_W = $clog2(BRICK_COUNT + 1);
    localparam int SERVE_W = $clog2(SERVE_DELAY + 1);

    localparam logic [BRICK_W-1:0] BRICKS_FULL = BRICK_W'(BRICK_COUNT);
    localparam logic [SERVE_W-1:0] SERVE_FULL  = SERVE_W'(SERVE_DELAY);
    localparam logic [1:0]         LIVES_LOAD  = 2'(LIVES_INIT);
    localparam logic [SCORE_W:0]   SCORE_INC   = (SCORE_W + 1)'(POINTS_PER_BRICK);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_GAMEOVER = 3'd3,
        ST_WIN      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [BRICK_W-1:0]   bricks_left_q, bricks_left_d;
    logic [SERVE_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic                 start_press_q, start_press_d;
    logic                 launch_q, launch_d;
    logic                 ball_reset_q, ball_reset_d;
    logic                 bricks_reset_q, bricks_reset_d;
    logic                 paddle_enable_q, paddle_enable_d;

    logic                 press_edge;
    logic                 launch_cond;
    logic                 serve_full;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;

    assign press_edge = start_press & ~start_press_q;
    assign serve_full = (serve_cnt_q == SERVE_FULL);

    // The carry bit of the widened sum flags overflow, which clamps to all-ones.
    assign score_sum  = {1'b0, score_q} + SCORE_INC;
    assign score_sat  = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

`ifdef GAME_SEQUENCER_AUTO_SERVE_EN
    assign launch_cond = 1'b1;
`else
    assign launch_cond = press_edge;
`endif

    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        score_d        = score_q;
        bricks_left_d  = bricks_left_q;
        serve_cnt_d    = serve_cnt_q;
        start_press_d  = start_press;
        launch_d       = 1'b0;
        ball_reset_d   = 1'b0;
        bricks_reset_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAMEOVER, ST_WIN: begin
                if (press_edge) begin
                    bricks_reset_d = 1'b1;
                    ball_reset_d   = 1'b1;
                    lives_d        = LIVES_LOAD;
                    score_d        = '0;
                    bricks_left_d  = BRICKS_FULL;
                    serve_cnt_d    = '0;
                    state_d        = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (refresh_tick && !serve_full) begin
                    serve_cnt_d = serve_cnt_q + 1'b1;
                end
                if (serve_full && launch_cond) begin
                    launch_d = 1'b1;
                    state_d  = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (brick_destroyed) begin
                    score_d = score_sat;
                    if (bricks_left_q != '0) begin
                        bricks_left_d = bricks_left_q - 1'b1;
                    end
                end
                // Clearing the wall outranks a simultaneous death.
                if (brick_destroyed && (bricks_left_q <= BRICK_W'(1))) begin
                    state_d = ST_WIN;
                end else if (ball_died) begin
                    if (lives_q > 2'd1) begin
                        lives_d      = lives_q - 2'd1;
                        ball_reset_d = 1'b1;
                        serve_cnt_d  = '0;
                        state_d      = ST_SERVE;
                    end else begin
                        lives_d = 2'd0;
                        state_d = ST_GAMEOVER;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        paddle_enable_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    end

    // start_press_q resets high so a button held through reset cannot start a game.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            lives_q         <= 2'd0;
            score_q         <= '0;
            bricks_left_q   <= '0;
            serve_cnt_q     <= '0;
            start_press_q   <= 1'b1;
            launch_q        <= 1'b0;
            ball_reset_q    <= 1'b0;
            bricks_reset_q  <= 1'b0;
            paddle_enable_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            lives_q         <= lives_d;
            score_q         <= score_d;
            bricks_left_q   <= bricks_left_d;
            serve_cnt_q     <= serve_cnt_d;
            start_press_q   <= start_press_d;
            launch_q        <= launch_d;
            ball_reset_q    <= ball_reset_d;
            bricks_reset_q  <= bricks_reset_d;
            paddle_enable_q <= paddle_enable_d;
        end
    end

    assign game_state    = state_q;
    assign lives         = lives_q;
    assign score         = score_q;
    assign launch        = launch_q;
    assign ball_reset    = ball_reset_q;
    assign bricks_reset  = bricks_reset_q;
    assign paddle_enable = paddle_enable_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed self-checking bench for game_sequencer, with a second
//               instance (SCORE_W=4, 20 bricks) for score saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_game_sequencer;

    logic       clk;
    logic       reset;
    logic       refresh_tick;
    logic       start_press;
    logic       ball_died;
    logic       brick_destroyed;

    logic       ball_reset, launch, bricks_reset, paddle_enable;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [9:0] score;

    logic       s_ball_reset, s_launch, s_bricks_reset, s_paddle_enable;
    logic [2:0] s_game_state;
    logic [1:0] s_lives;
    logic [3:0] s_score;

    int checks;
    int failures;

    game_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .refresh_tick    (refresh_tick),
        .start_press     (start_press),
        .ball_died       (ball_died),
        .brick_destroyed (brick_destroyed),
        .ball_reset      (ball_reset),
        .launch          (launch),
        .bricks_reset    (bricks_reset),
        .game_state      (game_state),
        .lives           (lives),
        .score           (score),
        .paddle_enable   (paddle_enable)
    );

    game_sequencer #(
        .SCORE_W     (4),
        .BRICK_COUNT (20)
    ) dut_small (
        .clk             (clk),
        .reset           (reset),
        .refresh_tick    (refresh_tick),
        .start_press     (start_press),
        .ball_died       (ball_died),
        .brick_destroyed (brick_destroyed),
        .ball_reset      (s_ball_reset),
        .launch          (s_launch),
        .bricks_reset    (s_bricks_reset),
        .game_state      (s_game_state),
        .lives           (s_lives),
        .score           (s_score),
        .paddle_enable   (s_paddle_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        start_press = 1'b1;
        step();
        start_press = 1'b0;
    endtask

    task automatic ticks(input int n);
        refresh_tick = 1'b1;
        repeat (n) step();
        refresh_tick = 1'b0;
    endtask

    task automatic brick();
        brick_destroyed = 1'b1;
        step();
        brick_destroyed = 1'b0;
    endtask

    task automatic die();
        ball_died = 1'b1;
        step();
        ball_died = 1'b0;
    endtask

    task automatic serve_and_launch(input string tag);
        ticks(60);
        press();
        checks++;
        if (launch !== 1'b1 || game_state !== 3'd2) begin
            failures++;
            $display("FAIL %s_launch launch=%b state=%0d expected launch=1 state=2", tag, launch, game_state);
        end
        step();
        checks++;
        if (launch !== 1'b0) begin
            failures++;
            $display("FAIL %s_launch_once launch=%b expected 0", tag, launch);
        end
    endtask

    task automatic test_reset();
        start_press = 1'b1;
        #3 reset = 1'b0;
        #1;
        checks++;
        if (game_state !== 3'd0 || lives !== 2'd0 || score !== 10'd0 || paddle_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_values state=%0d lives=%0d score=%0d paddle=%b expected 0/0/0/0", game_state, lives, score, paddle_enable);
        end
        checks++;
        if (launch !== 1'b0 || ball_reset !== 1'b0 || bricks_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes launch=%b ball_reset=%b bricks_reset=%b expected 000", launch, ball_reset, bricks_reset);
        end
        step();
        reset = 1'b1;
        repeat (4) step();
        checks++;
        if (game_state !== 3'd0 || bricks_reset !== 1'b0) begin
            failures++;
            $display("FAIL held_button_no_start state=%0d bricks_reset=%b expected 0/0", game_state, bricks_reset);
        end
        start_press = 1'b0;
        step();
        press();
        checks++;
        if (bricks_reset !== 1'b1 || ball_reset !== 1'b1 || launch !== 1'b0) begin
            failures++;
            $display("FAIL start_strobes bricks_reset=%b ball_reset=%b launch=%b expected 1/1/0", bricks_reset, ball_reset, launch);
        end
        checks++;
        if (game_state !== 3'd1 || lives !== 2'd3 || score !== 10'd0 || paddle_enable !== 1'b1) begin
            failures++;
            $display("FAIL start_state state=%0d lives=%0d score=%0d paddle=%b expected 1/3/0/1", game_state, lives, score, paddle_enable);
        end
        step();
        checks++;
        if (bricks_reset !== 1'b0 || ball_reset !== 1'b0) begin
            failures++;
            $display("FAIL start_strobes_once bricks_reset=%b ball_reset=%b expected 0/0", bricks_reset, ball_reset);
        end
    endtask

    task automatic test_serve();
        ticks(10);
        press();
        checks++;
        if (game_state !== 3'd1 || launch !== 1'b0) begin
            failures++;
            $display("FAIL early_press state=%0d launch=%b expected 1/0", game_state, launch);
        end
`ifdef GAME_SEQUENCER_AUTO_SERVE_EN
        ticks(50);
        checks++;
        if (game_state !== 3'd1 || launch !== 1'b0) begin
            failures++;
            $display("FAIL auto_hold state=%0d launch=%b expected 1/0", game_state, launch);
        end
        step();
        checks++;
        if (launch !== 1'b1 || game_state !== 3'd2) begin
            failures++;
            $display("FAIL auto_launch launch=%b state=%0d expected 1/2", launch, game_state);
        end
`else
        ticks(51);
        repeat (3) step();
        checks++;
        if (game_state !== 3'd1 || launch !== 1'b0) begin
            failures++;
            $display("FAIL wait_for_press state=%0d launch=%b expected 1/0", game_state, launch);
        end
        press();
        checks++;
        if (launch !== 1'b1 || game_state !== 3'd2) begin
            failures++;
            $display("FAIL press_launch launch=%b state=%0d expected 1/2", launch, game_state);
        end
`endif
        step();
        checks++;
        if (launch !== 1'b0 || game_state !== 3'd2) begin
            failures++;
            $display("FAIL launch_once launch=%b state=%0d expected 0/2", launch, game_state);
        end
    endtask

    task automatic test_play();
        repeat (5) brick();
        checks++;
        if (score !== 10'd5 || game_state !== 3'd2) begin
            failures++;
            $display("FAIL brick_score score=%0d state=%0d expected 5/2", score, game_state);
        end
        die();
        checks++;
        if (lives !== 2'd2 || ball_reset !== 1'b1 || game_state !== 3'd1 || score !== 10'd5) begin
            failures++;
            $display("FAIL death_serve lives=%0d ball_reset=%b state=%0d score=%0d expected 2/1/1/5", lives, ball_reset, game_state, score);
        end
        brick();
        die();
        checks++;
        if (score !== 10'd5 || lives !== 2'd2 || game_state !== 3'd1) begin
            failures++;
            $display("FAIL serve_ignores score=%0d lives=%0d state=%0d expected 5/2/1", score, lives, game_state);
        end
        // The serve counter restarted from zero, so 59 ticks are not enough.
        ticks(59);
        press();
        checks++;
        if (game_state !== 3'd1 || launch !== 1'b0) begin
            failures++;
            $display("FAIL serve_cnt_cleared state=%0d launch=%b expected 1/0", game_state, launch);
        end
        serve_and_launch("relaunch");
    endtask

    task automatic test_gameover();
        die();
        checks++;
        if (lives !== 2'd1 || game_state !== 3'd1) begin
            failures++;
            $display("FAIL second_death lives=%0d state=%0d expected 1/1", lives, game_state);
        end
        serve_and_launch("last_life");
        die();
        checks++;
        if (lives !== 2'd0 || game_state !== 3'd3 || ball_reset !== 1'b0 || paddle_enable !== 1'b0) begin
            failures++;
            $display("FAIL gameover lives=%0d state=%0d ball_reset=%b paddle=%b expected 0/3/0/0", lives, game_state, ball_reset, paddle_enable);
        end
        brick();
        die();
        checks++;
        if (score !== 10'd5 || lives !== 2'd0 || game_state !== 3'd3) begin
            failures++;
            $display("FAIL gameover_frozen score=%0d lives=%0d state=%0d expected 5/0/3", score, lives, game_state);
        end
        press();
        checks++;
        if (game_state !== 3'd1 || lives !== 2'd3 || score !== 10'd0 || bricks_reset !== 1'b1) begin
            failures++;
            $display("FAIL restart state=%0d lives=%0d score=%0d bricks_reset=%b expected 1/3/0/1", game_state, lives, score, bricks_reset);
        end
    endtask

    task automatic test_win();
        serve_and_launch("win");
        repeat (27) brick();
        checks++;
        if (score !== 10'd27 || game_state !== 3'd2) begin
            failures++;
            $display("FAIL before_last_brick score=%0d state=%0d expected 27/2", score, game_state);
        end
        brick_destroyed = 1'b1;
        ball_died       = 1'b1;
        step();
        brick_destroyed = 1'b0;
        ball_died       = 1'b0;
        checks++;
        if (game_state !== 3'd4 || lives !== 2'd3 || score !== 10'd28 || ball_reset !== 1'b0) begin
            failures++;
            $display("FAIL win_priority state=%0d lives=%0d score=%0d ball_reset=%b expected 4/3/28/0", game_state, lives, score, ball_reset);
        end
    endtask

    task automatic test_async_reset_saturation();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        press();
        serve_and_launch("sat");
        repeat (20) brick();
        checks++;
        if (s_score !== 4'd15 || s_game_state !== 3'd4) begin
            failures++;
            $display("FAIL score_saturation score=%0d state=%0d expected 15/4", s_score, s_game_state);
        end
        checks++;
        if (score !== 10'd20 || game_state !== 3'd2) begin
            failures++;
            $display("FAIL wide_score score=%0d state=%0d expected 20/2", score, game_state);
        end
        ball_died = 1'b1;
        step();
        ball_died = 1'b0;
        checks++;
        if (ball_reset !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_strobe ball_reset=%b expected 1", ball_reset);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (game_state !== 3'd0 || lives !== 2'd0 || score !== 10'd0 || paddle_enable !== 1'b0 || ball_reset !== 1'b0) begin
            failures++;
            $display("FAIL async_reset state=%0d lives=%0d score=%0d paddle=%b ball_reset=%b expected 0/0/0/0/0", game_state, lives, score, paddle_enable, ball_reset);
        end
        checks++;
        if (s_game_state !== 3'd0 || s_score !== 4'd0 || s_launch !== 1'b0 || s_bricks_reset !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_small state=%0d score=%0d launch=%b bricks_reset=%b expected 0/0/0/0", s_game_state, s_score, s_launch, s_bricks_reset);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        refresh_tick    = 1'b0;
        start_press     = 1'b0;
        ball_died       = 1'b0;
        brick_destroyed = 1'b0;

        test_reset();
        test_serve();
        test_play();
        test_gameover();
        test_win();
        test_async_reset_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
